// File: rtl/tl_bus_pkg.sv
// Shared TL bus definitions: opcode encodings, arbiter state codes and field widths.
// Imported by the slave-port arbiter and its round-robin picker.
package tl_bus_pkg;

   localparam int OPCODE_W = 3;

   localparam logic [OPCODE_W-1:0] OP_PUT_FULL_DATA   = 3'd0;
   localparam logic [OPCODE_W-1:0] OP_GET             = 3'd4;
   localparam logic [OPCODE_W-1:0] OP_ACCESS_ACK      = 3'd0;
   localparam logic [OPCODE_W-1:0] OP_ACCESS_ACK_DATA = 3'd1;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_REQ  = 2'd1;
   localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

   // Index width for n requesters; a single requester still gets a 1-bit id.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tl_slave_port_arbiter_rr_pick.sv
// Circular priority encoder: first set request strictly after rrPtr, wrapping around.
// Purely combinational; anyValid qualifies winner.
module rr_pick
   import tl_bus_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] rrPtr,
   output logic [IDX_W-1:0] winner,
   output logic             anyValid
);

   int bestDist;
   int curDist;

   // Distance from rrPtr+1 going round the ring; the smallest distance wins.
   always_comb begin
      winner   = '0;
      bestDist = N;
      curDist  = 0;
      for (int i = 0; i < N; i++) begin
         curDist = (i + N - 1 - int'(rrPtr)) % N;
         if (req[i] && (curDist < bestDist)) begin
            bestDist = curDist;
            winner   = IDX_W'(i);
         end
      end
   end

   assign anyValid = |req;

endmodule

// File: rtl/tl_slave_port_arbiter.sv
// Shares one TL slave port among NUM_MASTERS requesters, one transaction at a time,
// with round-robin grant, response routing back to the granted master and a response timeout.
module tl_slave_port_arbiter
   import tl_bus_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT     = 256
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_MASTERS-1:0]           m_a_valid,
   output logic [NUM_MASTERS-1:0]           m_a_ready,
   input  logic [3*NUM_MASTERS-1:0]         m_a_opcode,
   input  logic [ADDR_W*NUM_MASTERS-1:0]    m_a_address,
   input  logic [DATA_W*NUM_MASTERS-1:0]    m_a_data,
   output logic [NUM_MASTERS-1:0]           m_d_valid,
   input  logic [NUM_MASTERS-1:0]           m_d_ready,
   output logic [DATA_W-1:0]                m_d_data,
   output logic                             s_a_valid,
   input  logic                             s_a_ready,
   output logic [2:0]                       s_a_opcode,
   output logic [ADDR_W-1:0]                s_a_address,
   output logic [DATA_W-1:0]                s_a_data,
   input  logic                             s_d_valid,
   output logic                             s_d_ready,
   input  logic [DATA_W-1:0]                s_d_data,
   output logic                             busy,
   output logic [idxWidth(NUM_MASTERS)-1:0] grant_id,
   output logic                             timeout_err
);

   localparam int IDX_W = idxWidth(NUM_MASTERS);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [STATE_W-1:0]  stateReg;
   logic [IDX_W-1:0]    rrPtrReg;
   logic [IDX_W-1:0]    grantIdReg;
   logic [OPCODE_W-1:0] opcodeReg;
   logic [ADDR_W-1:0]   addrReg;
   logic [DATA_W-1:0]   dataReg;
   logic [CNT_W-1:0]    cntReg;

   logic [IDX_W-1:0]       winner;
   logic                   anyValid;
   logic [OPCODE_W-1:0]    selOpcode;
   logic [ADDR_W-1:0]      selAddr;
   logic [DATA_W-1:0]      selData;
   logic [NUM_MASTERS-1:0] grantOneHot;
   logic                   isIdle;
   logic                   isReq;
   logic                   isResp;
   logic                   dReadySel;
   logic                   dHandshake;
   logic                   timeoutHit;

   rr_pick #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req      (m_a_valid),
      .rrPtr    (rrPtrReg),
      .winner   (winner),
      .anyValid (anyValid)
   );

   assign isIdle = (stateReg == ST_IDLE);
   assign isReq  = (stateReg == ST_REQ);
   assign isResp = (stateReg == ST_RESP);

   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign grantOneHot[gi] = (grantIdReg == IDX_W'(gi));
      assign m_a_ready[gi]   = isIdle && anyValid && (winner == IDX_W'(gi));
      assign m_d_valid[gi]   = isResp && grantOneHot[gi] && s_d_valid;
   end

   always_comb begin
      selOpcode = '0;
      selAddr   = '0;
      selData   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (winner == IDX_W'(i)) begin
            selOpcode = m_a_opcode[i*3 +: 3];
            selAddr   = m_a_address[i*ADDR_W +: ADDR_W];
            selData   = m_a_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // IDLE keeps s_d_ready high so late responses from a timed-out slave are drained.
   assign dReadySel  = |(m_d_ready & grantOneHot);
   assign s_d_ready  = isIdle | (isResp & dReadySel);
   assign dHandshake = isResp & s_d_valid & s_d_ready;
   assign timeoutHit = (TIMEOUT != 0) && isResp && !dHandshake && (cntReg == CNT_LAST);

   assign m_d_data    = s_d_data;
   assign s_a_valid   = isReq;
   assign s_a_opcode  = opcodeReg;
   assign s_a_address = addrReg;
   assign s_a_data    = dataReg;
   assign busy        = !isIdle;
   assign grant_id    = grantIdReg;
   assign timeout_err = timeoutHit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateReg   <= ST_IDLE;
         rrPtrReg   <= IDX_W'(NUM_MASTERS - 1);
         grantIdReg <= '0;
         opcodeReg  <= '0;
         addrReg    <= '0;
         dataReg    <= '0;
         cntReg     <= '0;
      end else begin
         case (stateReg)
            ST_IDLE: begin
               if (anyValid) begin
                  opcodeReg  <= selOpcode;
                  addrReg    <= selAddr;
                  dataReg    <= selData;
                  grantIdReg <= winner;
                  stateReg   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (s_a_ready) begin
                  cntReg   <= '0;
                  stateReg <= ST_RESP;
               end
            end
            ST_RESP: begin
               // A handshake in the expiry cycle takes precedence over the timeout.
               if (dHandshake || timeoutHit) begin
                  rrPtrReg <= grantIdReg;
                  stateReg <= ST_IDLE;
               end else if (cntReg != '1) begin
                  cntReg <= cntReg + 1'b1;
               end
            end
            default: stateReg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/tl_slave_port_arbiter.md
Name: tl_slave_port_arbiter

Overview:
- Sequences one shared TL slave port among NUM_MASTERS requesters, one transaction at a time.
- Sits between the crossbar's master-side demux and one slave.
- Round-robin grant on channel A. Holds the grant until the matching channel-D response has been delivered back to the granted master.
- Response timeout guards against a dead slave. Stray responses are drained.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=1)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 256, RESP-state cycle limit; 0 disables timeout

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- m_a_valid  in  NUM_MASTERS  per-master request valid
- m_a_ready  out  NUM_MASTERS  per-master request accept
- m_a_opcode  in  3*NUM_MASTERS  per-master opcode, master i at [3i+2:3i]
- m_a_address  in  ADDR_W*NUM_MASTERS  per-master address
- m_a_data  in  DATA_W*NUM_MASTERS  per-master write data
- m_d_valid  out  NUM_MASTERS  per-master response valid
- m_d_ready  in  NUM_MASTERS  per-master response ready
- m_d_data  out  DATA_W  response data, shared; qualified by m_d_valid
- s_a_valid  out  1  slave request valid
- s_a_ready  in  1  slave request ready
- s_a_opcode  out  3  held opcode
- s_a_address  out  ADDR_W  held address
- s_a_data  out  DATA_W  held data
- s_d_valid  in  1  slave response valid
- s_d_ready  out  1  slave response ready
- s_d_data  in  DATA_W  slave response data
- busy  out  1  state != IDLE
- grant_id  out  clog2(NUM_MASTERS) (min 1)  current/last granted master
- timeout_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (reset low, async):
  - state=IDLE; rr_ptr=NUM_MASTERS-1, so master 0 has first priority; grant_id=0.
  - Hold registers cleared; timeout counter=0.
  - All valid/ready outputs 0, except s_d_ready=1 in IDLE. timeout_err=0.
- States: IDLE, REQ, RESP.
- IDLE:
  - If any m_a_valid, winner = first index i with m_a_valid[i], scanning circularly from rr_ptr+1.
  - Same cycle: m_a_ready[winner]=1, a one-cycle pulse; no other m_a_ready is ever high.
  - Next edge: latch opcode/address/data into hold registers, grant_id=winner, state→REQ.
  - s_d_ready=1: stray responses (late after a timeout) are accepted and dropped; m_d_valid stays 0.
- REQ:
  - s_a_valid=1 with held fields, stable until accepted.
  - On s_a_valid&s_a_ready → RESP, counter cleared.
  - No timeout in REQ.
- RESP:
  - m_d_valid[grant_id]=s_d_valid; m_d_data=s_d_data (combinational); s_d_ready=m_d_ready[grant_id]; all other m_d_valid=0.
  - On s_d_valid&s_d_ready: rr_ptr=grant_id, state→IDLE.
  - Else counter++. If TIMEOUT!=0 and counter==TIMEOUT-1 with no handshake: state→IDLE, timeout_err=1 for one cycle, rr_ptr=grant_id.
  - A handshake in the expiry cycle wins; no error is raised.
- Latency:
  - A accept → s_a_valid: 1 cycle. D handshake → next grant possible: 1 cycle (IDLE).
  - Minimum 3 cycles per transaction; no back-to-back pipelining.
- Simultaneous events:
  - New requests arriving during REQ/RESP are not acked.
  - Masters must hold m_a_valid until acked.
  - A requester deasserting m_a_valid before ack is simply skipped.
- Width rules: grant_id wraps modulo NUM_MASTERS; counter is clog2(TIMEOUT+1) bits and saturates.
- Reset mid-operation: transaction abandoned; slave-side cleanup is the system's responsibility.

Decomposition:
- Shared package tl_bus_pkg: opcode constants (Get=4, PutFullData=0, AccessAck=0, AccessAckData=1), arb state enum, field widths.
- One sub-module, rr_pick:
  - Combinational circular priority encoder.
  - Inputs: request vector, rr_ptr. Outputs: winner index, any-valid.

Test Plan:
- Single request: master0 valid, addr 0x0000_0010, opcode 4 → m_a_ready[0] pulse cycle 0; s_a_valid cycle 1 with addr 0x10; slave ready cycle 2, D data 0xDEADBEEF cycle 4 → m_d_valid[0], m_d_data 0xDEADBEEF, busy falls cycle 5.
- Round-robin fairness: both masters valid continuously, slave zero-wait → grant order 0,1,0,1 over four transactions; never two consecutive grants to the same master.
- Backpressure: s_a_ready low 5 cycles, then m_d_ready[1] low 3 cycles → s_a fields stable throughout; s_d_ready tracks m_d_ready[1]; exactly one D handshake.
- Timeout: TIMEOUT=8, slave never responds → timeout_err pulses in the 8th RESP cycle; IDLE next. A late s_d_valid afterwards is dropped with s_d_ready=1 and no m_d_valid.
- Async reset mid-RESP: assert reset between edges → s_a_valid, m_d_valid, busy go 0 immediately. After release, master1-only request is granted, grant_id=1.
- NUM_MASTERS=1 build: repeated requests all grant id 0; behaviour otherwise identical.
